// File: rtl/gpio_design_switcher.sv
// Hands the shared GPIO pads to one of NUM_DESIGNS user designs. The select input is
// synchronised and filtered, and the pads stay parked in a quiet state between owners.
module gpio_design_switcher #(
  parameter int NUM_DESIGNS   = 12,
  parameter int GPIO_WIDTH    = 34,
  parameter int SEL_WIDTH     = $clog2(NUM_DESIGNS + 1),
  parameter int STABLE_CYCLES = 4,
  parameter int QUIET_CYCLES  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SEL_WIDTH-1:0]              design_select,
  input  logic [GPIO_WIDTH-1:0]             gpio_in,
  output logic [GPIO_WIDTH-1:0]             designs_gpio_in,
  input  logic [NUM_DESIGNS*GPIO_WIDTH-1:0] designs_gpio_out,
  input  logic [NUM_DESIGNS*GPIO_WIDTH-1:0] designs_gpio_oeb,
  output logic [NUM_DESIGNS-1:0]            designs_ncs,
  output logic [GPIO_WIDTH-1:0]             gpio_out,
  output logic [GPIO_WIDTH-1:0]             gpio_oeb,
  output logic [SEL_WIDTH-1:0]              active_design,
  output logic                              busy,
  output logic                              sel_error
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [SEL_WIDTH-1:0] MAX_SEL    = SEL_WIDTH'(NUM_DESIGNS);
  localparam logic [CW-1:0]        STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [QW-1:0]        QUIET_LAST = QW'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {OFF, DRAIN, ACTIVE} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] s1, s2, s2m, cand, cand_next, target, drain_target;
  logic [CW-1:0]        cnt, cnt_next;
  logic [QW-1:0]        qcnt;

  assign designs_gpio_in = gpio_in;
  assign sel_error       = (s2 > MAX_SEL);

  always_comb begin
    s2m = (s2 > MAX_SEL) ? '0 : s2;
    if (s2m != cand) begin
      cand_next = s2m;
      cnt_next  = CW'(1);
    end else begin
      cand_next = cand;
      cnt_next  = (cnt == STABLE_MAX) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      cand   <= '0;
      cnt    <= '0;
      target <= '0;
    end else begin
      s1   <= design_select;
      s2   <= s1;
      cand <= cand_next;
      cnt  <= cnt_next;
      if (cnt_next == STABLE_MAX) target <= cand_next;
    end
  end

  // A target change inside DRAIN restarts the quiet period so the pads are never handed
  // over early.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= OFF;
      active_design <= '0;
      busy          <= 1'b0;
      qcnt          <= '0;
      drain_target  <= '0;
    end else begin
      case (state)
        OFF: begin
          if (target != '0) begin
            state        <= DRAIN;
            busy         <= 1'b1;
            qcnt         <= '0;
            drain_target <= target;
          end
        end
        ACTIVE: begin
          if (target != active_design) begin
            state         <= DRAIN;
            busy          <= 1'b1;
            active_design <= '0;
            qcnt          <= '0;
            drain_target  <= target;
          end
        end
        DRAIN: begin
          if (target != drain_target) begin
            qcnt         <= '0;
            drain_target <= target;
          end else if (qcnt == QUIET_LAST) begin
            busy <= 1'b0;
            if (target == '0) begin
              state <= OFF;
            end else begin
              state         <= ACTIVE;
              active_design <= target;
            end
          end else begin
            qcnt <= qcnt + 1'b1;
          end
        end
        default: begin
          state         <= OFF;
          busy          <= 1'b0;
          active_design <= '0;
        end
      endcase
    end
  end

  always_comb begin
    designs_ncs = '1;
    gpio_out    = '0;
    gpio_oeb    = '1;
    for (int k = 1; k <= NUM_DESIGNS; k++) begin
      if (active_design == SEL_WIDTH'(k)) begin
        designs_ncs[k-1] = 1'b0;
        gpio_out         = designs_gpio_out[(k-1)*GPIO_WIDTH +: GPIO_WIDTH];
        gpio_oeb         = designs_gpio_oeb[(k-1)*GPIO_WIDTH +: GPIO_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_gpio_design_switcher.sv
// Scoreboard bench for gpio_design_switcher: expected state changes are queued by the
// stimulus and matched by a monitor that also checks pads and chip selects every cycle.
`timescale 1ns/1ps
module tb_gpio_design_switcher;

  localparam int N  = 12;
  localparam int W  = 34;
  localparam int SW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [SW-1:0]  design_select;
  logic [W-1:0]   gpio_in, designs_gpio_in, gpio_out, gpio_oeb;
  logic [N*W-1:0] designs_gpio_out, designs_gpio_oeb;
  logic [N-1:0]   designs_ncs;
  logic [SW-1:0]  active_design;
  logic           busy, sel_error;
  logic [W-1:0]   pat_out [1:N];
  logic [W-1:0]   pat_oeb [1:N];

  logic [1:0]  sel_b, active_b;
  logic [7:0]  gpio_in_b, designs_gpio_in_b, gpio_out_b, gpio_oeb_b;
  logic [23:0] out_b, oeb_b;
  logic [2:0]  ncs_b;
  logic        busy_b, err_b;

  typedef struct packed {
    logic [31:0]   edge_n;
    logic [SW-1:0] act;
    logic          busy;
    logic          err;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_e;
  logic          mon_en = 1'b0;
  logic [SW+1:0] prev, cur;
  logic [SW-1:0] model_act;
  int            cyc = 0;
  int            ref_e;
  int            n_checks = 0;
  int            n_fail = 0;

  gpio_design_switcher dut (
    .clk(clk), .rst(rst), .design_select(design_select), .gpio_in(gpio_in),
    .designs_gpio_in(designs_gpio_in), .designs_gpio_out(designs_gpio_out),
    .designs_gpio_oeb(designs_gpio_oeb), .designs_ncs(designs_ncs),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .active_design(active_design),
    .busy(busy), .sel_error(sel_error)
  );

  gpio_design_switcher #(.NUM_DESIGNS(3), .GPIO_WIDTH(8), .QUIET_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .design_select(sel_b), .gpio_in(gpio_in_b),
    .designs_gpio_in(designs_gpio_in_b), .designs_gpio_out(out_b),
    .designs_gpio_oeb(oeb_b), .designs_ncs(ncs_b), .gpio_out(gpio_out_b),
    .gpio_oeb(gpio_oeb_b), .active_design(active_b), .busy(busy_b), .sel_error(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    for (int k = 1; k <= N; k++) begin
      designs_gpio_out[(k-1)*W +: W] = pat_out[k];
      designs_gpio_oeb[(k-1)*W +: W] = pat_oeb[k];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] exp_ncs(input logic [SW-1:0] a);
    exp_ncs = '1;
    if (a != '0) exp_ncs[a-1] = 1'b0;
  endfunction

  function automatic logic [W-1:0] exp_pad_out(input logic [SW-1:0] a);
    exp_pad_out = (a == '0) ? '0 : pat_out[a];
  endfunction

  function automatic logic [W-1:0] exp_pad_oeb(input logic [SW-1:0] a);
    exp_pad_oeb = (a == '0) ? '1 : pat_oeb[a];
  endfunction

  // Any change of {active_design, busy, sel_error} must match the next queued event.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {active_design, busy, sel_error};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          check("no_unexpected_event", {58'd0, cur}, {58'd0, prev});
        end else begin
          mon_e = exp_q.pop_front();
          check("event_edge", 64'(cyc), {32'd0, mon_e.edge_n});
          check("event_active", {60'd0, active_design}, {60'd0, mon_e.act});
          check("event_busy", {63'd0, busy}, {63'd0, mon_e.busy});
          check("event_sel_error", {63'd0, sel_error}, {63'd0, mon_e.err});
          model_act = mon_e.act;
        end
        prev = cur;
      end
      check("ncs", {52'd0, designs_ncs}, {52'd0, exp_ncs(model_act)});
      check("pad_out", {30'd0, gpio_out}, {30'd0, exp_pad_out(model_act)});
      check("pad_oeb", {30'd0, gpio_oeb}, {30'd0, exp_pad_oeb(model_act)});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [SW-1:0] sel);
    design_select = sel;
    ref_e = cyc;
  endtask

  task automatic expect_event(input int edge_n, input logic [SW-1:0] act,
                              input logic b, input logic e);
    ev_t ev;
    ev.edge_n = 32'(edge_n);
    ev.act    = act;
    ev.busy   = b;
    ev.err    = e;
    exp_q.push_back(ev);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick(1);
  endtask

  task automatic switch_to(input logic [SW-1:0] sel);
    apply_stimulus(sel);
    expect_event(ref_e + 7, '0, 1'b1, 1'b0);
    expect_event(ref_e + 11, sel, 1'b0, 1'b0);
    wait_drain(40);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    design_select = 4'd3;
    gpio_in = 34'h1_2345_6789;
    for (int k = 1; k <= N; k++) begin
      pat_out[k] = 34'h1_0000_0000 | 34'(k * 17);
      pat_oeb[k] = 34'h0_FFFF_0000 ^ 34'(k * 257);
    end
    sel_b = 2'd0;
    gpio_in_b = 8'h5A;
    out_b = {8'hC3, 8'h22, 8'h11};
    oeb_b = {8'h5A, 8'h0F, 8'hF0};

    tick(3);
    check("rst_active", {60'd0, active_design}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sel_error", {63'd0, sel_error}, 64'd0);
    check("rst_ncs", {52'd0, designs_ncs}, 64'hFFF);
    check("rst_pad_out", {30'd0, gpio_out}, 64'd0);
    check("rst_pad_oeb", {30'd0, gpio_oeb}, 64'h3_FFFF_FFFF);
    check("gpio_in_fanout", {30'd0, designs_gpio_in}, 64'h1_2345_6789);
    check("b_rst_ncs", {61'd0, ncs_b}, 64'h7);

    prev = '0;
    model_act = '0;
    mon_en = 1'b1;
    rst = 1'b0;
    switch_to(4'd3);

    switch_to(4'd0);
    switch_to(4'd5);
    pat_out[5] = 34'h2_AAAA_5555;
    #1;
    check("slot5_pad_same_cycle", {30'd0, gpio_out}, 64'h2_AAAA_5555);
    check("slot5_ncs_low", {63'd0, designs_ncs[4]}, 64'd0);

    tick(1);
    switch_to(4'd2);
    design_select = 4'd7;
    tick(2);
    design_select = 4'd2;
    tick(20);
    check("glitch_active", {60'd0, active_design}, 64'd2);
    check("glitch_busy", {63'd0, busy}, 64'd0);

    apply_stimulus(4'd4);
    expect_event(ref_e + 7, '0, 1'b1, 1'b0);
    expect_event(ref_e + 15, 4'd6, 1'b0, 1'b0);
    tick(4);
    design_select = 4'd6;
    wait_drain(40);

    switch_to(4'd2);
    apply_stimulus(4'd15);
    expect_event(ref_e + 2, 4'd2, 1'b0, 1'b1);
    expect_event(ref_e + 7, '0, 1'b1, 1'b1);
    expect_event(ref_e + 11, '0, 1'b0, 1'b1);
    wait_drain(40);
    check("oor_ncs", {52'd0, designs_ncs}, 64'hFFF);
    check("oor_pad_oeb", {30'd0, gpio_oeb}, 64'h3_FFFF_FFFF);
    apply_stimulus(4'd0);
    expect_event(ref_e + 2, '0, 1'b0, 1'b0);
    wait_drain(20);

    apply_stimulus(4'd7);
    expect_event(ref_e + 7, '0, 1'b1, 1'b0);
    tick(8);
    rst = 1'b1;
    expect_event(ref_e + 9, '0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    ref_e = cyc;
    expect_event(ref_e + 7, '0, 1'b1, 1'b0);
    expect_event(ref_e + 11, 4'd7, 1'b0, 1'b0);
    wait_drain(40);

    rst = 1'b1;
    design_select = 4'd0;
    expect_event(cyc + 1, '0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    wait_drain(10);
    tick(15);

    sel_b = 2'd3;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("b_busy_before_drain", {63'd0, busy_b}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("b_busy_drain", {63'd0, busy_b}, 64'd1);
    check("b_ncs_drain", {61'd0, ncs_b}, 64'h7);
    check("b_oeb_drain", {56'd0, gpio_oeb_b}, 64'hFF);
    @(posedge clk);
    @(negedge clk);
    check("b_busy_after", {63'd0, busy_b}, 64'd0);
    check("b_active", {62'd0, active_b}, 64'd3);
    check("b_ncs", {61'd0, ncs_b}, 64'h3);
    check("b_pad_out", {56'd0, gpio_out_b}, 64'hC3);
    check("b_pad_oeb", {56'd0, gpio_oeb_b}, 64'h5A);
    check("b_sel_error", {63'd0, err_b}, 64'd0);

    tick(2);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_design_switcher.md
# gpio_design_switcher

Parametrised successor to the fixed 12-way design mux. It selects one of NUM_DESIGNS user designs to drive the shared GPIO pads and adds behaviour the old mux lacked: a synchroniser and stability filter on the select input, out-of-range protection, and a quiet-time state machine. The state machine parks every pad in input mode, with all chip selects deasserted, before handing the pads to a newly selected design. It sits between the pad ring and the per-design wrappers.

## Interface
- NUM_DESIGNS, 12: number of design slots; slots are numbered 1..NUM_DESIGNS and 0 means none.
- GPIO_WIDTH, 34: pad count per design.
- SEL_WIDTH, $clog2(NUM_DESIGNS+1): width of the select input.
- STABLE_CYCLES, 4: consecutive synchronised samples required before a select value is accepted (≥1).
- QUIET_CYCLES, 4: cycles that pads stay safe between designs (≥1).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous and active-high.
- design_select  in  SEL_WIDTH  requested slot; asynchronous to clk.
- gpio_in  in  GPIO_WIDTH  pad inputs, fanned out unchanged to every design.
- designs_gpio_in  out  GPIO_WIDTH  copy of gpio_in for the design wrappers.
- designs_gpio_out  in  NUM_DESIGNS*GPIO_WIDTH  flattened per-slot outputs; slot k occupies bits [k*GPIO_WIDTH-1 : (k-1)*GPIO_WIDTH].
- designs_gpio_oeb  in  NUM_DESIGNS*GPIO_WIDTH  flattened per-slot output enables, active-low, same packing.
- designs_ncs  out  NUM_DESIGNS  active-low chip selects; bit k-1 selects slot k.
- gpio_out  out  GPIO_WIDTH  pad outputs.
- gpio_oeb  out  GPIO_WIDTH  pad output enables, active-low.
- active_design  out  SEL_WIDTH  slot currently driving the pads; 0 means none.
- busy  out  1  high while in DRAIN.
- sel_error  out  1  high while the synchronised select is greater than NUM_DESIGNS.

## Operation
- **Synchroniser:** two flops, s1 and s2. Any s2 value greater than NUM_DESIGNS is mapped to 0 (written s2m) and drives sel_error.
- **Stability filter:** a candidate register (cand) plus a counter.
  - If s2m differs from cand: load cand with s2m and set the counter to 1.
  - If s2m equals cand: increment the counter, saturating at STABLE_CYCLES.
  - When the counter reaches STABLE_CYCLES, target is loaded with cand.
- **FSM states:** OFF, DRAIN, ACTIVE.
  - OFF: active_design is 0. If target is nonzero, go to DRAIN.
  - ACTIVE: if target differs from active_design, go to DRAIN and clear active_design to 0 on the same edge.
  - DRAIN: the quiet counter counts QUIET_CYCLES cycles. At expiry:
    - target = 0: go to OFF.
    - otherwise: go to ACTIVE and load active_design with target.
  - If target changes while in DRAIN, the quiet counter restarts and the new target is used at expiry.
- **Chip selects:** designs_ncs[k-1] is low only when active_design = k; all bits are high otherwise.
- **Pad mux:** combinational, indexed by the registered active_design.
  - active_design = 0: gpio_out is all 0 and gpio_oeb is all 1.
  - otherwise: gpio_out and gpio_oeb pass through the selected slot's signals with zero latency.
- Unselected designs receive no pad outputs; their outputs are ignored.

## Timing
- Reset values (on the first clk edge with rst high):
  - s1, s2, cand, counter, target and active_design: 0.
  - State: OFF.
  - designs_ncs: all 1.
  - gpio_out: all 0; gpio_oeb: all 1.
  - busy and sel_error: 0.
- A reset asserted mid-DRAIN or mid-ACTIVE forces these values on the next edge, with no drain period.
- Switch latency, where design_select changes between edge 0 and edge 1 and stays stable (S = STABLE_CYCLES, Q = QUIET_CYCLES):

| Edge | Event |
|---|---|
| 2 | s2 updates |
| 2+S | target updates |
| 3+S | DRAIN entered; old slot's ncs high; pads safe; busy = 1 |
| 3+S+Q | ACTIVE entered; new slot's ncs low; busy = 0 |

- With the defaults (S = 4, Q = 4), DRAIN is entered at edge 7 and the new design is active at edge 11.
- Select glitch: a pulse lasting fewer than S cycles at s2 never reaches target.
- A new select that equals active_design causes no DRAIN.
- There is never a cycle in which two ncs bits are low at the same time.
- There is never a cycle in which a design drives the pads while its ncs is high.

## Test plan
- **Reset:** hold rst with design_select = 3 → ncs = all 1, gpio_oeb = all 1, gpio_out = 0, active_design = 0. Release rst → slot 3 active at edge 11 after release.
- **Switch:** switch 0 → 5 with defaults → busy high on edges 7..10, ncs[4] low from edge 11. Drive slot 5 gpio_out = 34'h2_AAAA_5555 → that value appears on the pads in the same cycle.
- **Glitch filter:** in ACTIVE on slot 2, pulse design_select to 7 for 2 cycles → active_design stays 2 and busy never rises.
- **Change during DRAIN:** switch 2 → 4, then change the select to 6 during DRAIN → quiet counter restarts and slot 6 becomes active. Slot 4's ncs never goes low.
- **Out of range:** select 15 with NUM_DESIGNS = 12 → sel_error high from edge 2. Slot 2 drains to OFF, all pads are safe, and all ncs are high.
- **Parametrisation:** NUM_DESIGNS = 3, GPIO_WIDTH = 8, Q = 1 → slot 3 packing is correct and DRAIN lasts exactly 1 cycle.
